sample_fifo8: RTL and testbench

SAMPLE_FIFO8 -- requirements
Module: sample_fifo8

---
 rtl/sample_fifo8_pkg.sv | 32 +++
 rtl/sf_ram.sv | 36 +++
 rtl/sample_fifo8.sv | 85 ++++++++
 tb/tb_sample_fifo8.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo8_pkg.sv
// Shared constants and the per-cycle operation decode for the sample FIFO.
// The decode is kept here so the accept/drop rules are defined in one place.
package sample_fifo8_pkg;

    localparam int SF_WIDTH = 8;
    localparam int SF_DEPTH = 8;
    localparam int SF_AW    = 3;

    typedef struct packed {
        logic wr_acc;
        logic rd_acc;
        logic wr_drop;
        logic rd_drop;
    } sf_op_t;

    // A write into a full FIFO is still accepted when a read frees a slot
    // on the same edge; a read from an empty FIFO never falls through.
    function automatic sf_op_t sf_decode(
        input logic wr_en,
        input logic rd_en,
        input logic full,
        input logic empty
    );
        sf_op_t op;
        op.rd_acc  = rd_en & ~empty;
        op.wr_acc  = wr_en & (~full | op.rd_acc);
        op.wr_drop = wr_en & ~op.wr_acc;
        op.rd_drop = rd_en & ~op.rd_acc;
        return op;
    endfunction

endpackage

// File: rtl/sf_ram.sv
// Sample storage: one write port and one registered read port.
// The read register doubles as the FIFO output and clears synchronously.
module sf_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read samples the pre-write contents, so a same-address read/write
    // (full FIFO, both ports active) returns the oldest entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_fifo8.sv
// Synchronous sample FIFO: pointer, occupancy and sticky error-flag control
// around the sf_ram storage. Flags are decoded from the registered count.
module sample_fifo8
    import sample_fifo8_pkg::*;
#(
    parameter int WIDTH = SF_WIDTH,
    parameter int DEPTH = SF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       d_in,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       q_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = (DEPTH == SF_DEPTH) ? SF_AW : $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          udf_q;
    sf_op_t        op;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    always_comb begin
        op = sf_decode(wr_en, rd_en, full, empty);
    end

    // Pointers are exactly AW bits wide and wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (op.wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (op.rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({op.wr_acc, op.rd_acc})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (op.wr_drop) begin
                ovf_q <= 1'b1;
            end
            if (op.rd_drop) begin
                udf_q <= 1'b1;
            end
        end
    end

    sf_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sf_ram (
        .clk     (clk),
        .clr     (~reset_n),
        .wr_en   (op.wr_acc & reset_n),
        .wr_addr (wr_ptr),
        .wr_data (d_in),
        .rd_en   (op.rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (q_out)
    );

endmodule

// File: tb/tb_sample_fifo8.sv
// Self-checking bench for sample_fifo8: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sample_fifo8;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] d_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] q_out;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_q_out;
    bit               m_ovf;
    bit               m_udf;

    sample_fifo8 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_in      (d_in),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .q_out     (q_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue; pop before push so a full FIFO can
    // accept a write when it is read in the same cycle.
    always @(posedge clk) begin
        bit m_full, m_empty, do_rd, do_wr;
        if (!reset_n) begin
            m_q.delete();
            m_q_out = '0;
            m_ovf   = 0;
            m_udf   = 0;
        end else begin
            m_full  = (m_q.size() == DEPTH);
            m_empty = (m_q.size() == 0);
            do_rd   = rd_en && !m_empty;
            do_wr   = wr_en && (!m_full || do_rd);
            if (do_rd) m_q_out = m_q.pop_front();
            if (do_wr) m_q.push_back(d_in);
            if (wr_en && !do_wr) m_ovf = 1;
            if (rd_en && !do_rd) m_udf = 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_q_out",     32'(q_out),     32'(m_q_out));
            chk("model_count",     32'(count),     32'(m_q.size()));
            chk("model_full",      32'(full),      32'(m_q.size() == DEPTH));
            chk("model_empty",     32'(empty),     32'(m_q.size() == 0));
            chk("model_overflow",  32'(overflow),  32'(m_ovf));
            chk("model_underflow", 32'(underflow), 32'(m_udf));
        end
    end

    // Apply one cycle of inputs at a falling edge; returns at the next
    // falling edge with the result of that rising edge visible.
    task automatic step(input logic rst_n, input logic w, input logic r, input logic [WIDTH-1:0] d);
        reset_n = rst_n;
        wr_en   = w;
        rd_en   = r;
        d_in    = d;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},     32'(count),     32'd0);
        chk({tag, "_empty"},     32'(empty),     32'd1);
        chk({tag, "_full"},      32'(full),      32'd0);
        chk({tag, "_q_out"},     32'(q_out),     32'h00);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        int bias;
        reset_n = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        d_in    = 8'hFF;
        @(negedge clk);

        // Reset held for two edges with traffic requested
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        chk_reset_state("reset");
        check_en = 1;

        // Fill then drain
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("drain_q_out", 32'(q_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Overflow, then simultaneous read/write while full
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd8);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        chk("fullrw_q_out",    32'(q_out),    32'h01);
        chk("fullrw_count",    32'(count),    32'd8);
        chk("fullrw_overflow", 32'(overflow), 32'd1);
        for (int i = 2; i <= 9; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("ovf_drain_q_out", 32'(q_out), (i == 9) ? 32'h55 : 32'(i));
        end
        chk("ovf_drain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty, then interleaving across wraps
        step(1'b1, 1'b1, 1'b1, 8'h33);
        chk("emptyrw_underflow", 32'(underflow), 32'd1);
        chk("emptyrw_count",     32'(count),     32'd1);
        chk("emptyrw_q_out",     32'(q_out),     32'h55);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("emptyrw_pop", 32'(q_out), 32'h33);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("wrap_q_out", 32'(q_out), 32'(8'h40 + i));
        end

        // Reset in the middle of a fill
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        chk("midfill_count", 32'(count), 32'd5);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk_reset_state("midrst");
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("postrst_count", 32'(count), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("postrst_q_out", 32'(q_out), 32'h77);
        chk("postrst_empty", 32'(empty), 32'd1);

        // Random traffic with alternating fill/drain bias and rare resets
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 150) == 0) bias = (bias == 75) ? 25 : 75;
            step(($urandom_range(0, 249) != 0),
                 ($urandom_range(0, 99) < bias),
                 ($urandom_range(0, 99) < (100 - bias)),
                 8'($urandom));
        end

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
